regfile_wb: RTL



---
 rtl/cpu_pkg.sv | 13 +
 rtl/regfile_wb_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/regfile_wb.sv | 41 ++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU widths and types used by decode, the register file and write-back.
package cpu_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/regfile_wb_if.sv
// Decode / write-back bus into the register file.
// Handshake: decode presents an instruction with IssueValid; it is accepted in
// any cycle where Stall is low, otherwise decode must hold it unchanged.
interface regfile_wb_if;
  import cpu_pkg::*;

  reg_addr_t               ReadReg1;
  reg_addr_t               ReadReg2;
  logic                    Read1Used;
  logic                    Read2Used;
  logic                    IssueValid;
  logic                    IssueWrEn;
  reg_addr_t               IssueDest;
  logic                    WbEn;
  reg_addr_t               WbReg;
  data_t                   WbData;
  data_t                   DataOut1;
  data_t                   DataOut2;
  logic                    Stall;
  logic [NUM_REGS-1:0]     Pending;
  logic                    ErrUnderflow;

  modport master (
    output ReadReg1, ReadReg2, Read1Used, Read2Used,
    output IssueValid, IssueWrEn, IssueDest,
    output WbEn, WbReg, WbData,
    input  DataOut1, DataOut2, Stall, Pending, ErrUnderflow
  );

  modport slave (
    input  ReadReg1, ReadReg2, Read1Used, Read2Used,
    input  IssueValid, IssueWrEn, IssueDest,
    input  WbEn, WbReg, WbData,
    output DataOut1, DataOut2, Stall, Pending, ErrUnderflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register count of in-flight writes; produces Stall, Pending and the
// sticky underflow flag.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  reg_addr_t           read_reg1,
  input  reg_addr_t           read_reg2,
  input  logic                read1_used,
  input  logic                read2_used,
  input  logic                issue_valid,
  input  logic                issue_wr_en,
  input  reg_addr_t           issue_dest,
  input  logic                wb_en,
  input  reg_addr_t           wb_reg,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending,
  output logic                err_underflow
);
  cnt_t                cnt [NUM_REGS];
  cnt_t                eff [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  always_comb begin
    dec     = '0;
    inc     = '0;
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r]     = wb_en && (wb_reg == reg_addr_t'(r)) && (cnt[r] != '0);
      eff[r]     = cnt[r] - cnt_t'(dec[r]);
      pending[r] = (cnt[r] != '0);
    end
    // The saturation guard looks at the post-write-back count so an issue
    // paired with a retiring write to the same full register still goes.
    stall = (read1_used && (eff[read_reg1] != '0)) ||
            (read2_used && (eff[read_reg2] != '0)) ||
            (issue_valid && issue_wr_en && (eff[issue_dest] == CNT_MAX));
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = issue_valid && issue_wr_en && !stall && (issue_dest == reg_addr_t'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt[r] + cnt_t'(inc[r]) - cnt_t'(dec[r]);
      end
      if (wb_en && (cnt[wb_reg] == '0)) err_underflow <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Register array with write-back bypass on both read ports, plus the
// in-flight write scoreboard that stalls decode.
module regfile_wb
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);
  data_t rf [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (bus.WbEn) begin
      rf[bus.WbReg] <= bus.WbData;
    end
  end

  always_comb begin
    bus.DataOut1 = (bus.WbEn && (bus.WbReg == bus.ReadReg1)) ? bus.WbData : rf[bus.ReadReg1];
    bus.DataOut2 = (bus.WbEn && (bus.WbReg == bus.ReadReg2)) ? bus.WbData : rf[bus.ReadReg2];
  end

  reg_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .read_reg1     (bus.ReadReg1),
    .read_reg2     (bus.ReadReg2),
    .read1_used    (bus.Read1Used),
    .read2_used    (bus.Read2Used),
    .issue_valid   (bus.IssueValid),
    .issue_wr_en   (bus.IssueWrEn),
    .issue_dest    (bus.IssueDest),
    .wb_en         (bus.WbEn),
    .wb_reg        (bus.WbReg),
    .stall         (bus.Stall),
    .pending       (bus.Pending),
    .err_underflow (bus.ErrUnderflow)
  );
endmodule
